ntt_masked_a2b_conv46: RTL

- Upstream feeder of the masked MLDSA multiply-reduction stage.
- Takes the 46-bit product held as two arithmetic shares, with a0 + a1 = p mod 2^46.
- Produces the per-bit Boolean-masked form x[i][1:0], with x[i][0] ^ x[i][1] = bit i of p, which the reduction stage consumes directly.
- Fully pipelined: one new conversion per cycle, with valid tracking and zeroize support.

---
 rtl/ntt_defines_pkg.sv | 20 ++
 rtl/ntt_masked_a2b_conv46_if.sv | 31 +++
 rtl/ntt_masked_fa_stage.sv | 58 +++++
 rtl/ntt_masked_a2b_conv46.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ntt_defines_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntt_defines_pkg
// Brief    : Shared widths, latency and masked-bit type for the masked
//            arithmetic-to-Boolean converter feeding the MLDSA reduction.
// Revision : 1.0 - initial release
// ============================================================================
package ntt_defines_pkg;

   // Width of the arithmetic product; the modulus is 2^MLDSA_PROD_W
   localparam int MLDSA_PROD_W = 46;

   // Input register + one ripple stage per bit + output register
   localparam int A2B_LATENCY  = MLDSA_PROD_W + 2;

   // Two Boolean shares of one bit: [0] = domain 0, [1] = domain 1
   typedef logic [1:0] masked_bit_t;

endpackage
`default_nettype wire

// File: rtl/ntt_masked_a2b_conv46_if.sv
`default_nettype none
// ============================================================================
// Module   : ntt_masked_a2b_conv46_if
// Brief    : Data/valid/randomness bundle of the masked A2B converter.
//            master = producer/consumer side, slave = converter side.
// Revision : 1.0 - initial release
// ============================================================================
interface ntt_masked_a2b_conv46_if;
   import ntt_defines_pkg::*;

   logic                        zeroize;
   logic                        valid_i;
   logic [MLDSA_PROD_W-1:0]     a0_i;
   logic [MLDSA_PROD_W-1:0]     a1_i;
   logic [2*MLDSA_PROD_W-1:0]   rnd_mask_i;
   logic [2*MLDSA_PROD_W-1:0]   rnd_and_i;
   logic                        valid_o;
   masked_bit_t                 x_o [MLDSA_PROD_W];

   modport master (
      output zeroize, valid_i, a0_i, a1_i, rnd_mask_i, rnd_and_i,
      input  valid_o, x_o
   );

   modport slave (
      input  zeroize, valid_i, a0_i, a1_i, rnd_mask_i, rnd_and_i,
      output valid_o, x_o
   );

endinterface
`default_nettype wire

// File: rtl/ntt_masked_fa_stage.sv
`default_nettype none
// ============================================================================
// Module   : ntt_masked_fa_stage
// Brief    : One-bit two-share masked full adder. Sum and both DOM AND
//            gadgets (A&B and c&(A^B)) are registered; every cross-domain
//            product is blinded with a fresh bit before its register.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_masked_fa_stage
   import ntt_defines_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_zeroize,
   input  masked_bit_t i_a,
   input  masked_bit_t i_b,
   input  masked_bit_t i_c,
   input  logic [1:0]  i_rnd,
   output masked_bit_t o_s,
   output masked_bit_t o_c
);

   masked_bit_t w_t;
   masked_bit_t w_s;
   // per domain: {c&t cross, c&t inner, a&b cross, a&b inner}
   logic [3:0]  r_d0;
   logic [3:0]  r_d1;
   masked_bit_t r_s;

   // share-wise linear part, never mixes domains
   assign w_t = i_a ^ i_b;
   assign w_s = i_a ^ i_b ^ i_c;

   // register inner and blinded cross terms of both AND gadgets plus the sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d0 <= '0;
         r_d1 <= '0;
         r_s  <= '0;
      end else if (i_zeroize) begin
         r_d0 <= '0;
         r_d1 <= '0;
         r_s  <= '0;
      end else begin
         r_d0 <= {(i_c[0] & w_t[1]) ^ i_rnd[1], i_c[0] & w_t[0],
                  (i_a[0] & i_b[1]) ^ i_rnd[0], i_a[0] & i_b[0]};
         r_d1 <= {(i_c[1] & w_t[0]) ^ i_rnd[1], i_c[1] & w_t[1],
                  (i_a[1] & i_b[0]) ^ i_rnd[0], i_a[1] & i_b[1]};
         r_s  <= w_s;
      end
   end

   // carry-out shares are compressed only within their own domain
   assign o_c = {^r_d1, ^r_d0};
   assign o_s = r_s;

endmodule
`default_nettype wire

// File: rtl/ntt_masked_a2b_conv46.sv
`default_nettype none
// ============================================================================
// Module   : ntt_masked_a2b_conv46
// Brief    : Fully pipelined arithmetic (mod 2^46) to per-bit Boolean
//            masking conversion. Masked ripple-carry, one bit per stage,
//            triangular operand skew and mirrored sum deskew.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_masked_a2b_conv46
   import ntt_defines_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   ntt_masked_a2b_conv46_if.slave bus
);

   localparam int WIDTH   = MLDSA_PROD_W;
   localparam int LATENCY = A2B_LATENCY;

   masked_bit_t        w_carry [0:WIDTH];
   masked_bit_t        w_sum   [0:WIDTH-1];
   masked_bit_t        r_x     [0:WIDTH-1];
   logic [LATENCY-1:0] r_valid;

   // the adder starts with a zero carry in both domains
   assign w_carry[0] = 2'b00;

   generate
      for (genvar j = 0; j < WIDTH; j++) begin : g_bit
         // r_a[0]/r_b[0] is the masked input register; r_a[j] meets stage j+1
         masked_bit_t r_a [0:j];
         masked_bit_t r_b [0:j];
         masked_bit_t w_fa_s;

         // mask operand bit on entry, then delay it until its carry arrives
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int n = 0; n <= j; n++) begin
                  r_a[n] <= '0;
                  r_b[n] <= '0;
               end
            end else if (bus.zeroize) begin
               for (int n = 0; n <= j; n++) begin
                  r_a[n] <= '0;
                  r_b[n] <= '0;
               end
            end else begin
               r_a[0] <= {bus.rnd_mask_i[j], bus.a0_i[j] ^ bus.rnd_mask_i[j]};
               r_b[0] <= {bus.rnd_mask_i[WIDTH+j],
                          bus.a1_i[j] ^ bus.rnd_mask_i[WIDTH+j]};
               for (int n = 1; n <= j; n++) begin
                  r_a[n] <= r_a[n-1];
                  r_b[n] <= r_b[n-1];
               end
            end
         end

         ntt_masked_fa_stage u_fa (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_zeroize (bus.zeroize),
            .i_a       (r_a[j]),
            .i_b       (r_b[j]),
            .i_c       (w_carry[j]),
            .i_rnd     (bus.rnd_and_i[2*j+1:2*j]),
            .o_s       (w_fa_s),
            .o_c       (w_carry[j+1])
         );

         if (j < WIDTH-1) begin : g_deskew
            // early sum bits wait here so the whole word leaves together
            masked_bit_t r_s [0:WIDTH-2-j];

            // mirror delay line for finished sum shares
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  for (int n = 0; n <= WIDTH-2-j; n++) r_s[n] <= '0;
               end else if (bus.zeroize) begin
                  for (int n = 0; n <= WIDTH-2-j; n++) r_s[n] <= '0;
               end else begin
                  r_s[0] <= w_fa_s;
                  for (int n = 1; n <= WIDTH-2-j; n++) r_s[n] <= r_s[n-1];
               end
            end

            assign w_sum[j] = r_s[WIDTH-2-j];
         end else begin : g_last
            assign w_sum[j] = w_fa_s;
         end

         assign bus.x_o[j] = r_x[j];
      end
   endgenerate

   // output register; the final carry is dropped for mod 2^WIDTH wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) r_x[i] <= '0;
      end else if (bus.zeroize) begin
         for (int i = 0; i < WIDTH; i++) r_x[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) r_x[i] <= w_sum[i];
      end
   end

   // valid travels alongside the data; zeroize drops everything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (bus.zeroize) begin
         r_valid <= '0;
      end else begin
         r_valid <= {r_valid[LATENCY-2:0], bus.valid_i};
      end
   end

   assign bus.valid_o = r_valid[LATENCY-1];

endmodule
`default_nettype wire
